// File: rtl/fetch_unit.sv
// Instruction fetch: PC, one outstanding synchronous imem read and a 2-entry response buffer feeding IF/ID.
// Define FETCH_BYPASS_EN to let the head come straight from imem_rdata when the buffer is empty.
module fetch_unit #(
    parameter int WIDTH = 32,
    parameter int AW = 10,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect,
    input  logic [AW-1:0]    redirect_addr,
    output logic             imem_en,
    output logic [AW-1:0]    imem_addr,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] instr_out,
    output logic [AW-1:0]    addr_out,
    output logic             fetch_valid,
    output logic             flush_out
);

    logic [AW-1:0]    pc_q, pc_d;
    logic [AW-1:0]    req_addr_q, req_addr_d;
    logic             req_valid_q, req_valid_d;
    logic [1:0]       count_q, count_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] buf_instr_q [2];
    logic [WIDTH-1:0] buf_instr_d [2];
    logic [AW-1:0]    buf_addr_q [2];
    logic [AW-1:0]    buf_addr_d [2];

    logic             has_buf;
    logic             head_exists;
    logic [WIDTH-1:0] head_instr;
    logic [AW-1:0]    head_addr;
    logic             pop;
    logic             pop_buf;
    logic             push;
    logic             issue;
    logic             wr_ptr;
    logic [1:0]       occupancy;

    assign has_buf   = (count_q != 2'd0);
    assign occupancy = count_q + {1'b0, req_valid_q};
    assign wr_ptr    = rd_ptr_q ^ count_q[0];

    always_comb begin
        head_instr  = buf_instr_q[rd_ptr_q];
        head_addr   = buf_addr_q[rd_ptr_q];
`ifdef FETCH_BYPASS_EN
        head_exists = has_buf | req_valid_q;
        if (!has_buf) begin
            head_instr = imem_rdata;
            head_addr  = req_addr_q;
        end
`else
        head_exists = has_buf;
`endif
    end

    assign fetch_valid = head_exists & ~redirect;
    assign pop         = fetch_valid & ~stall;
    assign pop_buf     = pop & has_buf;
`ifdef FETCH_BYPASS_EN
    // A response consumed straight off the bypass never enters the buffer.
    assign push        = req_valid_q & ~redirect & ~(~has_buf & pop);
`else
    assign push        = req_valid_q & ~redirect;
`endif
    assign issue       = redirect | (occupancy < 2'd2) | pop;

    assign imem_en     = ~reset & issue;
    assign imem_addr   = redirect ? redirect_addr : pc_q;
    assign flush_out   = ~reset & redirect;
    assign instr_out   = fetch_valid ? head_instr : '0;
    assign addr_out    = fetch_valid ? head_addr : '0;

    always_comb begin
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        req_valid_d = 1'b0;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        if (redirect) begin
            pc_d        = redirect_addr + AW'(1);
            req_addr_d  = redirect_addr;
            req_valid_d = 1'b1;
            count_d     = 2'd0;
        end else begin
            if (issue) begin
                pc_d        = pc_q + AW'(1);
                req_addr_d  = pc_q;
                req_valid_d = 1'b1;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop_buf};
            if (pop_buf) begin
                rd_ptr_d = ~rd_ptr_q;
            end
        end
    end

    always_comb begin
        buf_instr_d = buf_instr_q;
        buf_addr_d  = buf_addr_q;
        if (push) begin
            buf_instr_d[wr_ptr] = imem_rdata;
            buf_addr_d[wr_ptr]  = req_addr_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            req_addr_q  <= '0;
            req_valid_q <= 1'b0;
            count_q     <= 2'd0;
            rd_ptr_q    <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            req_valid_q <= req_valid_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Buffer payload is only read while count says it is valid, so it needs no reset.
    always_ff @(posedge clk) begin
        buf_instr_q <= buf_instr_d;
        buf_addr_q  <= buf_addr_d;
    end

endmodule
